// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit/receive blocks
// Purpose : FSM state codes, parity mode codes and the default baud divider.
// Ports   : none (package).
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t START = 3'd1;
   localparam state_t DATA  = 3'd2;
   localparam state_t PAR   = 3'd3;
   localparam state_t STOP  = 3'd4;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // 50 MHz system clock, 9600 baud
   localparam int BAUD_9600_50M = 5208;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing one tick per CLK_DIV cycles
// Purpose : counts 0..CLK_DIV-1 while enabled and pulses tick on the last count.
//           The count is held at 0 while en=0, so every enable starts a full period.
// Ports   : clk  in  system clock
//           rst  in  synchronous active-high reset
//           en   in  count enable
//           tick out 1-cycle pulse on count CLK_DIV-1
module uart_baud_tick #(
   parameter int CLK_DIV = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_pkt_tx.sv
// rtl/uart_pkt_tx.sv - multi-byte UART packet transmitter
// Purpose : accepts an NBYTES-wide word on tx_valid/tx_ready and sends it as
//           back-to-back UART frames, byte 0 first, LSB first, with optional
//           parity and 1 or 2 stop bits.
// Ports   : clk       in  system clock
//           rst       in  synchronous active-high reset
//           data_in   in  packet word, sampled on accept
//           tx_valid  in  send request
//           tx_ready  out idle, can accept
//           tx_busy   out packet in progress
//           byte_done out pulse in the last cycle of each frame
//           pkt_done  out pulse in the last cycle of the packet
//           data_out  out serial line, idles high
module uart_pkt_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = BAUD_9600_50M,
   parameter int NBYTES    = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NBYTES*8-1:0] data_in,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                tx_busy,
   output logic                byte_done,
   output logic                pkt_done,
   output logic                data_out
);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("uart_pkt_tx: CLK_DIV must be >= 2");
   end
   if (NBYTES < 1) begin : g_bad_nbytes
      $error("uart_pkt_tx: NBYTES must be >= 1");
   end
   if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
      $error("uart_pkt_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_pkt_tx: STOP_BITS must be 1 or 2");
   end

   localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
   localparam logic LAST_STOP = (STOP_BITS == 2);

   state_t              state;
   logic [NBYTES*8-1:0] pkt_r;
   logic [BW-1:0]       byte_idx;
   logic [2:0]          bit_idx;
   logic                stop_idx;
   logic                tick;
   logic [7:0]          cur_byte;
   logic                par_bit;
   logic                last_stop;

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .tick (tick)
   );

   // pkt_r shifts down one byte per frame, so the current byte is always the low byte
   assign cur_byte  = pkt_r[7:0];
   assign par_bit   = (PARITY == PAR_ODD) ? ~^cur_byte : ^cur_byte;
   assign last_stop = (stop_idx == LAST_STOP);

   assign tx_ready  = (state == IDLE);
   assign tx_busy   = (state != IDLE);
   // Pulses coincide with the final cycle of the stop bit rather than following it
   assign byte_done = !rst && (state == STOP) && tick && last_stop;
   assign pkt_done  = byte_done && (byte_idx == LAST_BYTE);

   // data_out is loaded with the value of the state being entered, so the line
   // changes on the same edge as the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pkt_r    <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         data_out <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               data_out <= 1'b1;
               if (tx_valid) begin
                  state    <= START;
                  pkt_r    <= data_in;
                  byte_idx <= '0;
                  data_out <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  state    <= DATA;
                  bit_idx  <= '0;
                  data_out <= cur_byte[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == 3'd7) begin
                     stop_idx <= 1'b0;
                     if (PARITY != PAR_NONE) begin
                        state    <= PAR;
                        data_out <= par_bit;
                     end else begin
                        state    <= STOP;
                        data_out <= 1'b1;
                     end
                  end else begin
                     bit_idx  <= bit_idx + 3'd1;
                     data_out <= cur_byte[bit_idx + 3'd1];
                  end
               end
            end
            PAR: begin
               if (tick) begin
                  state    <= STOP;
                  stop_idx <= 1'b0;
                  data_out <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  if (!last_stop) begin
                     stop_idx <= 1'b1;
                  end else if (byte_idx != LAST_BYTE) begin
                     state    <= START;
                     byte_idx <= byte_idx + 1'b1;
                     pkt_r    <= pkt_r >> 8;
                     data_out <= 1'b0;
                  end else begin
                     state    <= IDLE;
                     data_out <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               data_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb/tb_uart_pkt_tx.sv - self-checking bench for uart_pkt_tx
// Purpose : four differently parameterised instances share reset and data;
//           each packet's line waveform is predicted from frame rules.
// Ports   : none (top-level bench).
module tb_uart_pkt_tx;

   localparam int CDIV [4] = '{4, 2, 3, 5};
   localparam int NB   [4] = '{2, 2, 2, 1};
   localparam int PRTY [4] = '{0, 1, 2, 0};
   localparam int SB   [4] = '{1, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic [3:0]  vld, dout, rdy, busy, bd, pd;

   int n_pass  = 0;
   int n_total = 0;

   logic [2:0] exp_q [$];

   always #5 clk = ~clk;

   uart_pkt_tx #(.CLK_DIV(CDIV[0]), .NBYTES(NB[0]), .PARITY(PRTY[0]), .STOP_BITS(SB[0])) u0 (
      .clk(clk), .rst(rst), .data_in(din), .tx_valid(vld[0]), .tx_ready(rdy[0]),
      .tx_busy(busy[0]), .byte_done(bd[0]), .pkt_done(pd[0]), .data_out(dout[0]));
   uart_pkt_tx #(.CLK_DIV(CDIV[1]), .NBYTES(NB[1]), .PARITY(PRTY[1]), .STOP_BITS(SB[1])) u1 (
      .clk(clk), .rst(rst), .data_in(din), .tx_valid(vld[1]), .tx_ready(rdy[1]),
      .tx_busy(busy[1]), .byte_done(bd[1]), .pkt_done(pd[1]), .data_out(dout[1]));
   uart_pkt_tx #(.CLK_DIV(CDIV[2]), .NBYTES(NB[2]), .PARITY(PRTY[2]), .STOP_BITS(SB[2])) u2 (
      .clk(clk), .rst(rst), .data_in(din), .tx_valid(vld[2]), .tx_ready(rdy[2]),
      .tx_busy(busy[2]), .byte_done(bd[2]), .pkt_done(pd[2]), .data_out(dout[2]));
   uart_pkt_tx #(.CLK_DIV(CDIV[3]), .NBYTES(NB[3]), .PARITY(PRTY[3]), .STOP_BITS(SB[3])) u3 (
      .clk(clk), .rst(rst), .data_in(din[7:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
      .tx_busy(busy[3]), .byte_done(bd[3]), .pkt_done(pd[3]), .data_out(dout[3]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // {data_out, byte_done, pkt_done, tx_busy, tx_ready}
   function automatic logic [4:0] obs_vec(input int k);
      return {dout[k], bd[k], pd[k], busy[k], rdy[k]};
   endfunction

   // Expected per-cycle {line, byte_done, pkt_done} for one packet
   task automatic build_exp(input int k, input logic [15:0] w);
      logic [7:0] by;
      logic       bits [$];
      exp_q.delete();
      for (int b = 0; b < NB[k]; b++) begin
         by = w[8*b +: 8];
         bits.delete();
         bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) bits.push_back(by[i]);
         if (PRTY[k] == 1) bits.push_back(($countones(by) % 2) == 1);
         if (PRTY[k] == 2) bits.push_back(($countones(by) % 2) == 0);
         for (int s = 0; s < SB[k]; s++) bits.push_back(1'b1);
         foreach (bits[j])
            for (int c = 0; c < CDIV[k]; c++) exp_q.push_back({bits[j], 2'b00});
         exp_q[exp_q.size()-1] = {1'b1, 1'b1, (b == NB[k] - 1)};
      end
   endtask

   // Called just after the accepting edge; ends at the negedge of the idle cycle
   task automatic expect_pkt(input int k, input logic [15:0] w);
      build_exp(k, w);
      foreach (exp_q[i]) begin
         @(negedge clk);
         chk($sformatf("u%0d_w%04h_cyc%0d", k, w, i + 1), obs_vec(k), {exp_q[i], 2'b10});
      end
      @(negedge clk);
      chk($sformatf("u%0d_w%04h_ready_after", k, w), obs_vec(k), 5'b10001);
   endtask

   task automatic send(input int k, input logic [15:0] w);
      @(negedge clk);
      chk($sformatf("u%0d_ready_before", k), rdy[k], 1'b1);
      din    = w;
      vld[k] = 1'b1;
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      din    = 16'($urandom);
      expect_pkt(k, w);
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      vld = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // idle after reset
      repeat (100) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) chk($sformatf("idle_u%0d", k), obs_vec(k), 5'b10001);
      end

      // basic two-byte packet, no parity
      send(0, 16'hA53C);

      // even and odd parity with two stop bits, CLK_DIV=2 on the even one
      send(1, 16'h0707);
      send(2, 16'h0707);

      // single-byte packet: byte_done and pkt_done together
      send(3, 16'h00C5);

      // tx_valid held high, data changed after accept, back-to-back packets
      @(negedge clk);
      din    = 16'h1234;
      vld[0] = 1'b1;
      @(posedge clk);
      #1 din = 16'hBEEF;
      expect_pkt(0, 16'h1234);
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      din    = 16'($urandom);
      expect_pkt(0, 16'hBEEF);

      // reset during data bit 3 of byte 0 (16'h5AC3: bit 3 of C3 is 0)
      @(negedge clk);
      din    = 16'h5AC3;
      vld[0] = 1'b1;
      @(posedge clk);
      #1 vld[0] = 1'b0;
      repeat (18) @(negedge clk);
      chk("rst_pre_bit3", obs_vec(0), 5'b00010);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk("rst_abort_idle", obs_vec(0), 5'b10001);
      end
      send(0, 16'h5AC3);

      // randomized packets on every instance
      for (int r = 0; r < 6; r++)
         for (int k = 0; k < 4; k++) send(k, 16'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
